// File: rtl/mult_div_seq.sv
// Iterative signed multiply/divide sequencer for the multicycle CPU.
// 32-step shift-add multiply or restoring divide on operand magnitudes,
// sign fix-up in FIX, result written to the Hi/Lo registers, and a busy/done
// handshake plus a divide-by-zero pulse for the exception path.
module mult_div_seq #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int unsigned CNT_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    ITER,
    FIX,
    DONE,
    DZ
  } stateT;

  stateT               state;
  stateT               stateNext;
  logic [CNT_W-1:0]    stepCnt;
  logic                opReg;
  logic                signA;
  logic                signB;
  logic [DATA_W-1:0]   divisor;
  // Multiplier (shifting right) for MULT, dividend (shifting left) for DIV.
  logic [DATA_W-1:0]   workReg;
  logic [2*DATA_W-1:0] mcand;
  logic [2*DATA_W-1:0] prodAcc;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   quot;

  logic [DATA_W-1:0]   absA;
  logic [DATA_W-1:0]   absB;
  logic                accept;
  logic                lastStep;
  logic [DATA_W:0]     divShift;
  logic [DATA_W:0]     divTrial;

  // Operand magnitudes, acceptance decode and the restoring-divide trial subtract.
  always_comb begin
    absA     = a_in[DATA_W-1] ? ('0 - a_in) : a_in;
    absB     = b_in[DATA_W-1] ? ('0 - b_in) : b_in;
    accept   = (state == IDLE) && start && !(op && (b_in == '0));
    lastStep = (stepCnt == CNT_W'(DATA_W - 1));
    divShift = {rem, workReg[DATA_W-1]};
    divTrial = divShift - {1'b0, divisor};
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic; status outputs decode the current state only.
  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    done      = 1'b0;
    div_zero  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext = (op && (b_in == '0)) ? DZ : ITER;
        end
      end
      ITER: begin
        busy = 1'b1;
        if (lastStep) begin
          stateNext = FIX;
        end
      end
      FIX: begin
        busy      = 1'b1;
        stateNext = DONE;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      DZ: begin
        div_zero  = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Operand latch, per-step iteration and final sign fix-up into Hi/Lo.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stepCnt <= '0;
      opReg   <= 1'b0;
      signA   <= 1'b0;
      signB   <= 1'b0;
      divisor <= '0;
      workReg <= '0;
      mcand   <= '0;
      prodAcc <= '0;
      rem     <= '0;
      quot    <= '0;
      hi      <= '0;
      lo      <= '0;
    end else if (accept) begin
      stepCnt <= '0;
      opReg   <= op;
      signA   <= a_in[DATA_W-1];
      signB   <= b_in[DATA_W-1];
      divisor <= absB;
      workReg <= op ? absA : absB;
      mcand   <= {{DATA_W{1'b0}}, absA};
      prodAcc <= '0;
      rem     <= '0;
      quot    <= '0;
    end else if (state == ITER) begin
      stepCnt <= stepCnt + 1'b1;
      if (!opReg) begin
        if (workReg[0]) begin
          prodAcc <= prodAcc + mcand;
        end
        mcand   <= mcand << 1;
        workReg <= workReg >> 1;
      end else begin
        // Partial remainder always stays below the divisor, so DATA_W bits hold it.
        rem     <= divTrial[DATA_W] ? divShift[DATA_W-1:0] : divTrial[DATA_W-1:0];
        quot    <= {quot[DATA_W-2:0], ~divTrial[DATA_W]};
        workReg <= workReg << 1;
      end
    end else if (state == FIX) begin
      if (!opReg) begin
        {hi, lo} <= (signA ^ signB) ? ('0 - prodAcc) : prodAcc;
      end else begin
        lo <= (signA ^ signB) ? ('0 - quot) : quot;
        hi <= signA ? ('0 - rem) : rem;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq: a cycle-level behavioural model
// compared against the DUT on every falling edge, plus directed cases with
// literal results and randomized MULT/DIV traffic.
module tb_mult_div_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int nVec = 0;
  int nErr = 0;
  bit chkEn = 1'b0;

  // Model state: mK = -1 idle, -2 in the div-by-zero cycle, >= 0 cycles since accept.
  int          mK;
  logic        mBusy, mDone, mDz;
  logic [31:0] mHi, mLo;
  logic [63:0] mRes;

  mult_div_seq #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed result {hi,lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] refResult(input logic o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r, p;
    logic [63:0] qv, rv, pv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!o) begin
      p  = sa * sb;
      pv = p;
      return pv;
    end
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  // Behavioural model advanced on every active edge / reset.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mK = -1; mBusy = 1'b0; mDone = 1'b0; mDz = 1'b0; mHi = '0; mLo = '0;
    end else begin
      mDone = 1'b0;
      mDz   = 1'b0;
      if (mK == -2) begin
        mK = -1;
      end else if (mK >= 0) begin
        mK++;
        if (mK == 33) begin
          mBusy = 1'b0;
          mDone = 1'b1;
          mHi   = mRes[63:32];
          mLo   = mRes[31:0];
        end else if (mK == 34) begin
          mK = -1;
        end
      end else if (start) begin
        if (op && b_in == 32'd0) begin
          mDz = 1'b1;
          mK  = -2;
        end else begin
          mRes  = refResult(op, a_in, b_in);
          mBusy = 1'b1;
          mK    = 0;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chkEn) begin
      check("busy", {31'd0, busy}, {31'd0, mBusy});
      check("done", {31'd0, done}, {31'd0, mDone});
      check("div_zero", {31'd0, div_zero}, {31'd0, mDz});
      check("hi", hi, mHi);
      check("lo", lo, mLo);
      check("busyDoneExclusive", {31'd0, busy & done}, 32'd0);
    end
  end

  function automatic logic [31:0] pickVal();
    case ($urandom_range(0, 9))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0000_0000;
      3: return 32'h0000_0001;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One request from IDLE, observed for 40 cycles; optional re-pulse / reset injection.
  task automatic doOp(input logic o, input logic [31:0] a, input logic [31:0] b,
                      input int repAt, input int rstAt,
                      input bit useLit, input logic [31:0] eHi, input logic [31:0] eLo);
    int  doneAt, dzAt, busyCnt, donePulses;
    bit  isDz;
    doneAt = 0; dzAt = 0; busyCnt = 0; donePulses = 0;
    isDz = o && (b == 32'd0);
    @(negedge clk);
    start = 1'b1; op = o; a_in = a; b_in = b;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (busy) busyCnt++;
      if (done) begin
        donePulses++;
        if (doneAt == 0) doneAt = n;
      end
      if (div_zero && dzAt == 0) dzAt = n;
      if (n == 1) begin
        start = 1'b0; op = 1'($urandom); a_in = $urandom; b_in = $urandom;
      end
      if (n == repAt) begin
        start = 1'b1; op = 1'($urandom_range(0, 1)); a_in = $urandom; b_in = $urandom;
      end
      if (n == repAt + 1) start = 1'b0;
      if (rstAt > 0 && n == rstAt) begin
        #3 reset = 1'b1;
        #1;
        check("rstBusy", {31'd0, busy}, 32'd0);
        check("rstDone", {31'd0, done}, 32'd0);
        check("rstDz", {31'd0, div_zero}, 32'd0);
        check("rstHi", hi, 32'd0);
        check("rstLo", lo, 32'd0);
      end
      if (rstAt > 0 && n == rstAt + 1) begin
        #3 reset = 1'b0;
      end
    end
    if (rstAt > 0) begin
      check("noDoneAfterReset", 32'(donePulses), 32'd0);
    end else if (isDz) begin
      check("dzCycle", 32'(dzAt), 32'd1);
      check("dzNoDone", 32'(donePulses), 32'd0);
      check("dzNoBusy", 32'(busyCnt), 32'd0);
    end else begin
      check("doneCycle", 32'(doneAt), 32'd34);
      check("donePulses", 32'(donePulses), 32'd1);
      check("busyCycles", 32'(busyCnt), 32'd33);
    end
    if (useLit) begin
      check("litHi", hi, eHi);
      check("litLo", lo, eLo);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
    #1 reset = 1'b1;
    #1 chkEn = 1'b1;
    repeat (2) @(negedge clk);
    check("resetHi", hi, 32'd0);
    check("resetLo", lo, 32'd0);
    check("resetBusy", {31'd0, busy}, 32'd0);
    #3 reset = 1'b0;

    doOp(1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 0, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    doOp(1'b0, 32'h8000_0000, 32'h8000_0000, 0, 0, 1'b1, 32'h4000_0000, 32'h0000_0000);
    doOp(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b1, 32'h0000_0000, 32'h0000_0001);
    doOp(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    doOp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b1, 32'h0000_0000, 32'h8000_0000);
    doOp(1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 0, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    doOp(1'b1, 32'h0000_0005, 32'h0000_0000, 0, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    doOp(1'b0, 32'h0000_1234, 32'h0000_0010, 10, 0, 1'b1, 32'h0000_0000, 32'h0001_2340);
    doOp(1'b1, 32'h0000_0064, 32'hFFFF_FFF9, 0, 0, 1'b1, 32'h0000_0002, 32'hFFFF_FFF2);
    doOp(1'b0, 32'h0000_0003, 32'h0000_0005, 0, 15, 1'b1, 32'h0000_0000, 32'h0000_0000);
    doOp(1'b0, 32'h0000_0064, 32'h0000_00C8, 0, 0, 1'b1, 32'h0000_0000, 32'h0000_4E20);

    for (int i = 0; i < 40; i++) begin
      doOp(1'($urandom_range(0, 1)), pickVal(), pickVal(), 0, 0, 1'b0, '0, '0);
    end

    chkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/mult_div_seq.md
# mult_div_seq

Iterative signed multiply/divide sequencer serving the multicycle CPU's MULT and DIV instructions. The main control unit pulses `start` with the operands already held in the A and B registers. The block runs a 32-step shift-add multiply or restoring divide, then writes the 64-bit result into its internal Hi/Lo registers. It reports completion to the control unit through a `busy`/`done` handshake and flags divide-by-zero for the exception path.

## Interface
- `DATA_W`, 32, operand width; the iteration count equals `DATA_W`. Only 32 is required to be supported.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request from the control unit; sampled only in IDLE.
- `op`  in  1  0 = MULT, 1 = DIV; sampled with `start`.
- `a_in`  in  32  rs operand (multiplicand / dividend), signed.
- `b_in`  in  32  rt operand (multiplier / divisor), signed.
- `busy`  out  1  high while an operation is in progress (states ITER, FIX).
- `done`  out  1  one-cycle pulse; `hi`/`lo` hold the new result during it.
- `div_zero`  out  1  one-cycle pulse when DIV is requested with `b_in` = 0.
- `hi`  out  32  Hi register: product[63:32] or remainder.
- `lo`  out  32  Lo register: product[31:0] or quotient.

## Operation
- States: IDLE, ITER, FIX, DONE, DZ.
- IDLE with `start`=1:
  - If `op`=1 and `b_in`=0, go to DZ.
  - Otherwise latch `op`, the operand signs, and |`a_in`|, |`b_in`|; clear the 6-bit step counter; go to ITER.
- IDLE with `start`=0: stay in IDLE.
- ITER, MULT: 64-bit unsigned shift-add on the magnitudes, one multiplier bit per cycle, LSB first.
- ITER, DIV: restoring division, one quotient bit per cycle, MSB first.
  - 33-bit partial remainder.
  - Trial subtract; keep the result if it is non-negative.
- ITER ends after exactly 32 steps (counter reaches 31), then goes to FIX.
- FIX, MULT: negate the 64-bit magnitude product if the operand signs differ; write {`hi`,`lo`}.
- FIX, DIV:
  - Negate the quotient if the operand signs differ.
  - Give the remainder the dividend's sign.
  - Write `lo`=quotient, `hi`=remainder.
- FIX then goes to DONE.
- DONE: `done`=1 for this cycle only, then go to IDLE unconditionally.
- DZ: `div_zero`=1 for this cycle only; `hi`/`lo` are not modified; `busy` stays 0; go to IDLE.
- Arithmetic is two's complement and truncated to 32 bits per result half.
  - 0x80000000 ÷ −1 gives `lo`=0x80000000, `hi`=0; no overflow flag.
  - The magnitude of 0x80000000 is handled as an unsigned 32-bit value (0x80000000), with no loss of precision.
- `start` is ignored in ITER, FIX, DONE and DZ; there is no queuing.
- `op`, `a_in` and `b_in` may change freely after the `start` edge; the operands are latched internally.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0, counter 0.
- Reset asserted mid-operation aborts immediately, returns all outputs to their reset values, and produces no `done` pulse.
- Edge E0 samples `start`. Normal path:
  - ITER occupies cycles E0..E32.
  - FIX occupies E32..E33.
  - DONE occupies E33..E34.
- Latency: `done` is high in the 34th cycle after the sampling edge (cycle E33..E34).
- `hi`/`lo` change only at edge E33 and are stable from then until the next FIX.
- `busy` rises after E0 and falls after E33; `busy` and `done` are never high together.
- Div-by-zero path: `div_zero` is high in cycle E0..E1; back in IDLE after E1.
- Earliest next accepted `start` is at edge E34 (normal path) or E1 (DZ).
- The control unit holds its wait state until `done` or `div_zero` is seen.
- Combinational paths: `busy`, `done` and `div_zero` decode state only; there is no combinational path from any input to any output.

## Test plan
- MULT 7 × −3 (0x00000007, 0xFFFFFFFD):
  - `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
  - `done` high exactly in cycle E33; `busy` high for 33 cycles.
- MULT 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0x00000000.
- MULT 0xFFFFFFFF × 0xFFFFFFFF (−1 × −1) → `hi`=0, `lo`=1.
- DIV −7 ÷ 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIV 0x80000000 ÷ 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIV 5 ÷ 0 with `hi`/`lo` preloaded by a prior MULT:
  - `div_zero` is a single pulse in E0..E1.
  - `busy` stays 0 and `done` never rises.
  - `hi`/`lo` are unchanged.
- `start` re-pulsed at E10 with different operands → ignored; the result matches the first request.
- `reset` asserted at E15 → outputs are zero immediately and no `done` pulse follows.
- A new MULT accepted at E0 again completes normally.
